mem_responder: RTL and testbench

Memory-side responder for the cache bus. It accepts line-granular read and write requests from the cache on the request channel (`bus_reqcyc`/`bus_reqack`) and returns read data as an 8-beat burst on the response channel (`bus_respcyc`/`bus_respack`). It sits between the L1 cache and the backing store, and it doubles as the memory model in cache testbenches. One request is outstanding at a time.

---
 rtl/mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Line-granular memory responder: accepts read/write line requests, answers reads with a wrapped 8-beat burst.
// Latency: request ack one cycle after sampling; first read beat LATENCY cycles after the ack; one GAP cycle between beats.
// Backpressure: a response beat is held stable until bus_respack; requests are not acked while a read is in flight.

`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 64
`endif
`ifndef BUS_TAG_WIDTH
`define BUS_TAG_WIDTH 4
`endif
`ifndef MEM_READ
`define MEM_READ 1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2
`endif

module mem_responder #(
   parameter int DATA_W    = `BUS_DATA_WIDTH,
   parameter int TAG_W     = `BUS_TAG_WIDTH,
   parameter int MEM_LINES = 1024,
   parameter int BEATS     = 8,
   parameter int LATENCY   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_reqcyc,
   output logic              bus_reqack,
   input  logic [DATA_W-1:0] bus_req,
   input  logic [TAG_W-1:0]  bus_reqtag,
   output logic              bus_respcyc,
   input  logic              bus_respack,
   output logic [DATA_W-1:0] bus_resp,
   output logic [TAG_W-1:0]  bus_resptag
);

   localparam int LINE_W = $clog2(MEM_LINES);
   localparam int BEAT_W = $clog2(BEATS);
   localparam int OFF_W  = $clog2(DATA_W/8);
   localparam int LAT_W  = $clog2(LATENCY+1);
   localparam int WORD_W = LINE_W + BEAT_W;

   localparam logic [TAG_W-1:0]  TAG_RD    = TAG_W'(`MEM_READ);
   localparam logic [TAG_W-1:0]  TAG_WR    = TAG_W'(`MEM_WRITE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_WAIT,
      S_RESP,
      S_GAP
   } state_t;

   // Backing store; contents survive reset.
   logic [DATA_W-1:0] mem [MEM_LINES*BEATS];

   state_t             state_q, state_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [BEAT_W-1:0]  start_q, start_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [BEAT_W-1:0]  cnt_q, cnt_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               reqack_q, reqack_d;
   logic               respcyc_q, respcyc_d;
   logic [DATA_W-1:0]  resp_q, resp_d;
   logic [TAG_W-1:0]   resptag_q, resptag_d;

   logic               mem_we;
   logic [BEAT_W-1:0]  cur_beat;
   logic [WORD_W-1:0]  word_idx;
   logic [LINE_W-1:0]  addr_line;
   logic [BEAT_W-1:0]  addr_beat;

   // Upper address bits fall away here, so lines alias modulo the memory size.
   assign addr_line = bus_req[OFF_W+BEAT_W +: LINE_W];
   assign addr_beat = bus_req[OFF_W +: BEAT_W];

   // Critical-word-first: beat counter offsets from the start word and wraps inside the line.
   assign cur_beat = start_q + cnt_q;
   assign word_idx = {line_q, cur_beat};

   assign bus_reqack  = reqack_q;
   assign bus_respcyc = respcyc_q;
   assign bus_resp    = resp_q;
   assign bus_resptag = resptag_q;

   // Next-state and registered-output decode; a beat is only taken when the ack is not already high.
   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      start_d   = start_q;
      tag_d     = tag_q;
      cnt_d     = cnt_q;
      lat_d     = lat_q;
      reqack_d  = 1'b0;
      respcyc_d = 1'b0;
      resp_d    = '0;
      resptag_d = '0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus_reqcyc && !reqack_q) begin
               reqack_d = 1'b1;
               line_d   = addr_line;
               start_d  = addr_beat;
               tag_d    = bus_reqtag;
               cnt_d    = '0;
               if (bus_reqtag == TAG_WR) begin
                  state_d = S_WDATA;
               end else if (bus_reqtag == TAG_RD) begin
                  state_d = S_WAIT;
                  lat_d   = LAT_W'(LATENCY);
               end
            end
         end
         S_WDATA: begin
            if (bus_reqcyc && !reqack_q) begin
               reqack_d = 1'b1;
               mem_we   = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            // The counter is loaded at the ack cycle, so leaving on 1 puts beat 0 out LATENCY cycles after the ack.
            lat_d = lat_q - 1'b1;
            if (lat_q == LAT_W'(1)) begin
               state_d   = S_RESP;
               respcyc_d = 1'b1;
               resp_d    = mem[word_idx];
               resptag_d = tag_q;
            end
         end
         S_RESP: begin
            if (bus_respack) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = cnt_q + 1'b1;
               end
            end else begin
               respcyc_d = 1'b1;
               resp_d    = resp_q;
               resptag_d = resptag_q;
            end
         end
         S_GAP: begin
            state_d   = S_RESP;
            respcyc_d = 1'b1;
            resp_d    = mem[word_idx];
            resptag_d = tag_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers; reset abandons any burst in flight and clears every output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         line_q    <= '0;
         start_q   <= '0;
         tag_q     <= '0;
         cnt_q     <= '0;
         lat_q     <= '0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         start_q   <= start_d;
         tag_q     <= tag_d;
         cnt_q     <= cnt_d;
         lat_q     <= lat_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
      end
   end

   // Storage write port; no reset so committed data outlives a reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= bus_req;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 64
`endif
`ifndef BUS_TAG_WIDTH
`define BUS_TAG_WIDTH 4
`endif
`ifndef MEM_READ
`define MEM_READ 1
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2
`endif

module tb_mem_responder;
   localparam int DW = `BUS_DATA_WIDTH;
   localparam int TW = `BUS_TAG_WIDTH;
   localparam int LINES = 1024;
   localparam int NB = 8;
   localparam int LAT = 4;
   localparam logic [TW-1:0] T_RD = TW'(`MEM_READ);
   localparam logic [TW-1:0] T_WR = TW'(`MEM_WRITE);

   logic          clk = 1'b0;
   logic          reset;
   logic          bus_reqcyc;
   logic          bus_reqack;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic          bus_respcyc;
   logic          bus_respack;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;

   mem_responder dut (
      .clk(clk), .reset(reset),
      .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // reference memory: word w of line l lives at l*NB+w
   logic [DW-1:0] model_mem [LINES*NB];
   logic [DW-1:0] wbuf [NB];

   logic [DW-1:0] obs_data [$];
   logic [TW-1:0] obs_tag [$];
   int            obs_start [$];
   int            obs_end [$];
   int            ack_cyc, unstable, idle_nz, extra_ack;

   function automatic int line_of(input logic [DW-1:0] a);
      return int'((a / 64) % LINES);
   endfunction

   function automatic int beat_of(input logic [DW-1:0] a);
      return int'((a / 8) % NB);
   endfunction

   function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] a, input int i);
      return model_mem[line_of(a) * NB + (beat_of(a) + i) % NB];
   endfunction

   task automatic do_write(input logic [DW-1:0] addr, output int a0, output int alast, output bit to);
      int n;
      to = 0; a0 = 0; alast = 0;
      @(negedge clk);
      bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = T_WR;
      for (int i = -1; i < NB; i++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!bus_reqack && n < 50);
         if (!bus_reqack) to = 1;
         if (i == -1) a0 = cyc; else alast = cyc;
         if (i + 1 < NB) bus_req = wbuf[i+1];
      end
      bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
      for (int i = 0; i < NB; i++)
         model_mem[line_of(addr) * NB + (beat_of(addr) + i) % NB] = wbuf[i];
   endtask

   task automatic do_read(input logic [DW-1:0] addr, input int hold_beat, input int hold_n,
                          input bit rnd, input bit sticky, output bit to);
      int n, held;
      bit prev;
      logic [DW-1:0] cur;
      obs_data.delete(); obs_tag.delete(); obs_start.delete(); obs_end.delete();
      unstable = 0; idle_nz = 0; extra_ack = 0; held = 0; prev = 0; cur = '0; to = 0;
      @(negedge clk);
      bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = T_RD; bus_respack = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_reqack && n < 50);
      if (!bus_reqack) to = 1;
      ack_cyc = cyc;
      if (!sticky) begin bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; end
      n = 0;
      while (obs_end.size() < NB && n < 500) begin
         @(negedge clk); n++;
         if (bus_reqack) extra_ack++;
         if (bus_respcyc) begin
            if (!prev) begin
               cur = bus_resp;
               obs_data.push_back(bus_resp);
               obs_tag.push_back(bus_resptag);
               obs_start.push_back(cyc);
            end else if (bus_resp !== cur) begin
               unstable++;
            end
            if (obs_data.size() - 1 == hold_beat && held < hold_n) begin
               bus_respack = 1'b0; held++;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
               bus_respack = 1'b0;
            end else begin
               bus_respack = 1'b1; obs_end.push_back(cyc);
            end
         end else begin
            if (bus_resp !== '0 || bus_resptag !== '0) idle_nz++;
            bus_respack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         prev = bus_respcyc;
      end
      if (obs_end.size() != NB) to = 1;
      bus_respack = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus_reqcyc = 1'b1; bus_req = '1; bus_reqtag = T_RD; bus_respack = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus_reqack !== 1'b0) begin bad++; $display("FAIL rst_reqack got=%0h exp=0", bus_reqack); end
      total++; if (bus_respcyc !== 1'b0) begin bad++; $display("FAIL rst_respcyc got=%0h exp=0", bus_respcyc); end
      total++; if (bus_resp !== '0) begin bad++; $display("FAIL rst_resp got=%0h exp=0", bus_resp); end
      total++; if (bus_resptag !== '0) begin bad++; $display("FAIL rst_resptag got=%0h exp=0", bus_resptag); end
      bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      total++; if ({bus_reqack, bus_respcyc} !== 2'b00) begin bad++; $display("FAIL rst_idle got=%0b exp=00", {bus_reqack, bus_respcyc}); end
   endtask

   task automatic test_write_read();
      int a0, al; bit to;
      for (int i = 0; i < NB; i++) wbuf[i] = 64'h11 * (i + 1);
      do_write(64'h40, a0, al, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL wr_timeout got=%0b exp=0", to); end
      total++; if (al - a0 != 2 * NB) begin bad++; $display("FAIL wr_ack_spacing got=%0d exp=%0d", al - a0, 2 * NB); end
      do_read(64'h40, -1, 0, 0, 0, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL rd_timeout got=%0b exp=0", to); end
      total++; if (obs_data.size() != NB) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", obs_data.size(), NB); end
      for (int i = 0; i < obs_data.size(); i++) begin
         total++; if (obs_data[i] !== 64'h11 * (i + 1)) begin bad++; $display("FAIL wr_rd_beat%0d got=%0h exp=%0h", i, obs_data[i], 64'h11 * (i + 1)); end
         total++; if (obs_tag[i] !== T_RD) begin bad++; $display("FAIL wr_rd_tag%0d got=%0h exp=%0h", i, obs_tag[i], T_RD); end
      end
      if (obs_start.size() > 0) begin
         total++; if (obs_start[0] - ack_cyc != LAT) begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", obs_start[0] - ack_cyc, LAT); end
      end
      for (int i = 0; i + 1 < obs_start.size() && i < obs_end.size(); i++) begin
         total++; if (obs_start[i+1] - obs_end[i] != 2) begin bad++; $display("FAIL rd_gap%0d got=%0d exp=2", i, obs_start[i+1] - obs_end[i]); end
      end
      total++; if (idle_nz != 0) begin bad++; $display("FAIL rd_idle_zero got=%0d exp=0", idle_nz); end
   endtask

   task automatic test_critical_word();
      bit to;
      logic [DW-1:0] e;
      do_read(64'h68, -1, 0, 0, 0, to);
      total++; if (to !== 1'b0 || obs_data.size() != NB) begin bad++; $display("FAIL cwf_count got=%0d exp=%0d", obs_data.size(), NB); end
      for (int i = 0; i < obs_data.size(); i++) begin
         e = 64'h11 * (((5 + i) % NB) + 1);
         total++; if (obs_data[i] !== e) begin bad++; $display("FAIL cwf_beat%0d got=%0h exp=%0h", i, obs_data[i], e); end
      end
   endtask

   task automatic test_backpressure();
      int a0, al; bit to;
      for (int i = 0; i < NB; i++) wbuf[i] = {$urandom, $urandom};
      do_write(64'hD0, a0, al, to);
      do_read(64'hC0, 3, 10, 0, 0, to);
      total++; if (to !== 1'b0 || obs_data.size() != NB) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_data.size(), NB); end
      total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
      if (obs_start.size() > 4 && obs_end.size() > 3) begin
         total++; if (obs_end[3] - obs_start[3] != 10) begin bad++; $display("FAIL bp_hold got=%0d exp=10", obs_end[3] - obs_start[3]); end
         total++; if (obs_start[4] - obs_end[3] != 2) begin bad++; $display("FAIL bp_next got=%0d exp=2", obs_start[4] - obs_end[3]); end
      end
      for (int i = 0; i < obs_data.size(); i++) begin
         total++; if (obs_data[i] !== expect_word(64'hC0, i)) begin bad++; $display("FAIL bp_beat%0d got=%0h exp=%0h", i, obs_data[i], expect_word(64'hC0, i)); end
      end
   endtask

   task automatic test_sticky();
      bit to; int n, e;
      do_read(64'h40, -1, 0, 0, 1, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL sticky_timeout got=%0b exp=0", to); end
      total++; if (extra_ack != 0) begin bad++; $display("FAIL sticky_extra_ack got=%0d exp=0", extra_ack); end
      e = (obs_end.size() > 0) ? obs_end[obs_end.size()-1] + 2 : -1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_reqack && n < 30);
      total++; if (!bus_reqack || cyc != e) begin bad++; $display("FAIL sticky_second_ack got=%0d exp=%0d", cyc, e); end
      bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_alias();
      int a0, al; bit to;
      for (int i = 0; i < NB; i++) wbuf[i] = {$urandom, $urandom};
      do_write(64'(LINES * 64 + 64'h40), a0, al, to);
      do_read(64'h40, -1, 0, 0, 0, to);
      total++; if (to !== 1'b0 || obs_data.size() != NB) begin bad++; $display("FAIL alias_count got=%0d exp=%0d", obs_data.size(), NB); end
      for (int i = 0; i < obs_data.size(); i++) begin
         total++; if (obs_data[i] !== wbuf[i]) begin bad++; $display("FAIL alias_beat%0d got=%0h exp=%0h", i, obs_data[i], wbuf[i]); end
      end
   endtask

   task automatic test_bad_tag();
      int n; bit to;
      @(negedge clk);
      bus_reqcyc = 1'b1; bus_req = 64'h40; bus_reqtag = TW'(7);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_reqack && n < 20);
      total++; if (bus_reqack !== 1'b1) begin bad++; $display("FAIL badtag_ack got=%0b exp=1", bus_reqack); end
      bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
      n = 0;
      repeat (12) begin @(negedge clk); if (bus_respcyc || bus_reqack) n++; end
      total++; if (n != 0) begin bad++; $display("FAIL badtag_quiet got=%0d exp=0", n); end
      do_read(64'h40, -1, 0, 0, 0, to);
      total++; if (to !== 1'b0 || obs_data.size() == 0 || obs_data[0] !== wbuf[0]) begin bad++; $display("FAIL badtag_after got=%0h exp=%0h", (obs_data.size() > 0) ? obs_data[0] : '0, wbuf[0]); end
   endtask

   task automatic test_reset_midburst();
      int a0, al, n, seen; bit to, prev;
      for (int i = 0; i < NB; i++) wbuf[i] = {$urandom, $urandom};
      do_write(64'h140, a0, al, to);
      @(negedge clk);
      bus_reqcyc = 1'b1; bus_req = 64'h140; bus_reqtag = T_RD; bus_respack = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus_reqack && n < 50);
      bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
      seen = 0; prev = 0; n = 0;
      while (seen < 3 && n < 100) begin
         @(negedge clk); n++;
         if (bus_respcyc && !prev) seen++;
         prev = bus_respcyc;
      end
      total++; if (seen != 3) begin bad++; $display("FAIL mid_reach got=%0d exp=3", seen); end
      #1 reset = 1'b0;
      #1;
      total++; if (bus_respcyc !== 1'b0) begin bad++; $display("FAIL mid_respcyc got=%0b exp=0", bus_respcyc); end
      total++; if (bus_resp !== '0) begin bad++; $display("FAIL mid_resp got=%0h exp=0", bus_resp); end
      total++; if (bus_resptag !== '0) begin bad++; $display("FAIL mid_resptag got=%0h exp=0", bus_resptag); end
      total++; if (bus_reqack !== 1'b0) begin bad++; $display("FAIL mid_reqack got=%0b exp=0", bus_reqack); end
      @(negedge clk); reset = 1'b1;
      n = 0;
      repeat (16) begin @(negedge clk); if (bus_respcyc || bus_reqack) n++; end
      total++; if (n != 0) begin bad++; $display("FAIL mid_no_resume got=%0d exp=0", n); end
      do_read(64'h158, -1, 0, 0, 0, to);
      total++; if (to !== 1'b0 || obs_data.size() != NB) begin bad++; $display("FAIL mid_fresh_count got=%0d exp=%0d", obs_data.size(), NB); end
      for (int i = 0; i < obs_data.size(); i++) begin
         total++; if (obs_data[i] !== expect_word(64'h158, i)) begin bad++; $display("FAIL mid_fresh_beat%0d got=%0h exp=%0h", i, obs_data[i], expect_word(64'h158, i)); end
      end
   endtask

   task automatic test_random();
      int a0, al; bit to;
      logic [DW-1:0] wa, ra;
      for (int it = 0; it < 6; it++) begin
         wa = {$urandom, $urandom};
         ra = {$urandom, $urandom};
         ra[15:6] = wa[15:6];
         for (int i = 0; i < NB; i++) wbuf[i] = {$urandom, $urandom};
         do_write(wa, a0, al, to);
         total++; if (to !== 1'b0 || al - a0 < 2 * NB) begin bad++; $display("FAIL rnd_wr%0d got=%0d exp=%0d", it, al - a0, 2 * NB); end
         do_read(ra, $urandom_range(0, NB - 1), $urandom_range(0, 3), 1, 0, to);
         total++; if (to !== 1'b0 || obs_data.size() != NB) begin bad++; $display("FAIL rnd_count%0d got=%0d exp=%0d", it, obs_data.size(), NB); end
         total++; if (unstable != 0 || idle_nz != 0) begin bad++; $display("FAIL rnd_hold%0d got=%0d exp=0", it, unstable + idle_nz); end
         for (int i = 0; i < obs_data.size(); i++) begin
            total++; if (obs_data[i] !== expect_word(ra, i)) begin bad++; $display("FAIL rnd%0d_beat%0d got=%0h exp=%0h", it, i, obs_data[i], expect_word(ra, i)); end
         end
         for (int i = 0; i + 1 < obs_start.size() && i < obs_end.size(); i++) begin
            total++; if (obs_start[i+1] - obs_end[i] != 2) begin bad++; $display("FAIL rnd%0d_gap%0d got=%0d exp=2", it, i, obs_start[i+1] - obs_end[i]); end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b1;
      test_reset();
      test_write_read();
      test_critical_word();
      test_backpressure();
      test_sticky();
      test_alias();
      test_bad_tag();
      test_reset_midburst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
